pcie_vc_tx_port: RTL and testbench

Per-port transmit side of the two-VC switch link. It accepts words from an upstream source and buffers them in one FIFO per virtual channel. It drives the switch input (data_pX/valid_pX) and obeys that port's pause_VCx/continue_VCx flow-control pair. Two instances, one per port, sit in front of the switch in place of a free-running stimulus source.

---
 rtl/pcie_vc_tx_port_pkg.sv | 13 +
 rtl/pcie_vc_fifo.sv | 60 ++++++
 rtl/pcie_vc_tx_port.sv | 141 ++++++++++++++
 tb/tb_pcie_vc_tx_port.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pcie_vc_tx_port_pkg.sv
// Shared definitions for the two-VC switch link: word-field positions and VC ids.
package pcie_vc_tx_port_pkg;

  // Field positions inside a link word for the default BUS_SIZE of 5.
  localparam int VC_BIT  = 5;
  localparam int DST_BIT = 4;

  typedef enum logic {
    VC0 = 1'b0,
    VC1 = 1'b1
  } vc_e;

endpackage

// File: rtl/pcie_vc_fifo.sv
// Single-VC transmit FIFO.
// Occupancy comes from wrap-around write/read counters one bit wider than the address.
module pcie_vc_fifo #(
  parameter int ADDR_WIDTH = 3,
  parameter int BUS_SIZE   = 5,
  parameter int MEM_LENGTH = 1 << ADDR_WIDTH
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push_i,
  input  logic                pop_i,
  input  logic [BUS_SIZE:0]   data_i,
  output logic [BUS_SIZE:0]   data_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [ADDR_WIDTH:0] count_o
);

  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(MEM_LENGTH);

  logic [BUS_SIZE:0]   mem_q [MEM_LENGTH];
  logic [ADDR_WIDTH:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_WIDTH:0] rd_cnt_q, rd_cnt_d;
  logic                push_ok;
  logic                pop_ok;

  assign count_o = wr_cnt_q - rd_cnt_q;
  assign full_o  = (count_o == FULL_CNT);
  assign empty_o = (count_o == '0);
  assign data_o  = mem_q[rd_cnt_q[ADDR_WIDTH-1:0]];

  // A push into a full FIFO is refused even if a pop happens in the same cycle.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Next counter values.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (push_ok) wr_cnt_d = wr_cnt_q + 1'b1;
    if (pop_ok)  rd_cnt_d = rd_cnt_q + 1'b1;
  end

  // Counter registers; reset empties the FIFO.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_cnt_q[ADDR_WIDTH-1:0]] <= data_i;
  end

endmodule

// File: rtl/pcie_vc_tx_port.sv
// Per-port transmit side of the two-VC switch link: one FIFO per VC,
// pause/continue flow control, round-robin VC arbiter and registered output.
module pcie_vc_tx_port
  import pcie_vc_tx_port_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int BUS_SIZE   = 5,
  parameter int MEM_LENGTH = 1 << ADDR_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [BUS_SIZE:0]   in_data,
  input  logic                in_push,
  input  logic                pause_vc0,
  input  logic                continue_vc0,
  input  logic                pause_vc1,
  input  logic                continue_vc1,
  output logic [BUS_SIZE:0]   data_out,
  output logic                valid_out,
  output logic                full_vc0,
  output logic                full_vc1,
  output logic [ADDR_WIDTH:0] count_vc0,
  output logic [ADDR_WIDTH:0] count_vc1,
  output logic                overflow_err
);

  logic                push_vc0, push_vc1;
  logic                pop_vc0, pop_vc1;
  logic                empty_vc0, empty_vc1;
  logic [BUS_SIZE:0]   head_vc0, head_vc1;
  logic                elig_vc0, elig_vc1;

  logic                paused_vc0_q, paused_vc0_d;
  logic                paused_vc1_q, paused_vc1_d;
  vc_e                 rr_last_q, rr_last_d;
  logic [BUS_SIZE:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                overflow_q, overflow_d;

  assign push_vc0 = in_push && (vc_e'(in_data[BUS_SIZE]) == VC0);
  assign push_vc1 = in_push && (vc_e'(in_data[BUS_SIZE]) == VC1);

  pcie_vc_fifo #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BUS_SIZE   (BUS_SIZE),
    .MEM_LENGTH (MEM_LENGTH)
  ) u_fifo_vc0 (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (push_vc0),
    .pop_i   (pop_vc0),
    .data_i  (in_data),
    .data_o  (head_vc0),
    .full_o  (full_vc0),
    .empty_o (empty_vc0),
    .count_o (count_vc0)
  );

  pcie_vc_fifo #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BUS_SIZE   (BUS_SIZE),
    .MEM_LENGTH (MEM_LENGTH)
  ) u_fifo_vc1 (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (push_vc1),
    .pop_i   (pop_vc1),
    .data_i  (in_data),
    .data_o  (head_vc1),
    .full_o  (full_vc1),
    .empty_o (empty_vc1),
    .count_o (count_vc1)
  );

  // Pause flags: pause wins over continue; continue alone clears.
  always_comb begin
    paused_vc0_d = paused_vc0_q;
    paused_vc1_d = paused_vc1_q;
    if (pause_vc0)         paused_vc0_d = 1'b1;
    else if (continue_vc0) paused_vc0_d = 1'b0;
    if (pause_vc1)         paused_vc1_d = 1'b1;
    else if (continue_vc1) paused_vc1_d = 1'b0;
  end

  // Eligibility and round-robin pick; a live pause input blocks the VC this cycle.
  always_comb begin
    elig_vc0 = !empty_vc0 && !paused_vc0_q && !pause_vc0;
    elig_vc1 = !empty_vc1 && !paused_vc1_q && !pause_vc1;
    pop_vc0  = 1'b0;
    pop_vc1  = 1'b0;
    if (elig_vc0 && elig_vc1) begin
      if (rr_last_q == VC1) pop_vc0 = 1'b1;
      else                  pop_vc1 = 1'b1;
    end else if (elig_vc0) begin
      pop_vc0 = 1'b1;
    end else if (elig_vc1) begin
      pop_vc1 = 1'b1;
    end
  end

  // Output word, valid, round-robin pointer and sticky overflow next-state.
  always_comb begin
    data_d     = data_q;
    valid_d    = 1'b0;
    rr_last_d  = rr_last_q;
    overflow_d = overflow_q | (push_vc0 && full_vc0) | (push_vc1 && full_vc1);
    if (pop_vc0) begin
      data_d    = head_vc0;
      valid_d   = 1'b1;
      rr_last_d = VC0;
    end else if (pop_vc1) begin
      data_d    = head_vc1;
      valid_d   = 1'b1;
      rr_last_d = VC1;
    end
  end

  // State registers; reset favours VC0 for the first grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      paused_vc0_q <= 1'b0;
      paused_vc1_q <= 1'b0;
      rr_last_q    <= VC1;
      data_q       <= '0;
      valid_q      <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      paused_vc0_q <= paused_vc0_d;
      paused_vc1_q <= paused_vc1_d;
      rr_last_q    <= rr_last_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      overflow_q   <= overflow_d;
    end
  end

  assign data_out     = data_q;
  assign valid_out    = valid_q;
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_pcie_vc_tx_port.sv
// Self-checking bench for pcie_vc_tx_port: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_pcie_vc_tx_port;
  import pcie_vc_tx_port_pkg::*;

  localparam int AW    = 3;
  localparam int BS    = 5;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic [BS:0]   in_data;
  logic          in_push;
  logic          pause_vc0, continue_vc0, pause_vc1, continue_vc1;
  logic [BS:0]   data_out;
  logic          valid_out;
  logic          full_vc0, full_vc1;
  logic [AW:0]   count_vc0, count_vc1;
  logic          overflow_err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [BS:0] mq0[$];
  logic [BS:0] mq1[$];
  bit          mp0, mp1;
  bit          mrr_vc1;
  logic [BS:0] mdata;
  bit          mvalid;
  bit          movf;

  pcie_vc_tx_port #(
    .ADDR_WIDTH (AW),
    .BUS_SIZE   (BS),
    .MEM_LENGTH (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_push      (in_push),
    .pause_vc0    (pause_vc0),
    .continue_vc0 (continue_vc0),
    .pause_vc1    (pause_vc1),
    .continue_vc1 (continue_vc1),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .full_vc0     (full_vc0),
    .full_vc1     (full_vc1),
    .count_vc0    (count_vc0),
    .count_vc1    (count_vc1),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq0.delete();
    mq1.delete();
    mp0 = 0; mp1 = 0;
    mrr_vc1 = 1;
    mdata = '0;
    mvalid = 0;
    movf = 0;
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".valid"}, 32'(valid_out), 32'(mvalid));
    check_eq({tag, ".data"}, 32'(data_out), 32'(mdata));
    check_eq({tag, ".cnt0"}, 32'(count_vc0), 32'(mq0.size()));
    check_eq({tag, ".cnt1"}, 32'(count_vc1), 32'(mq1.size()));
    check_eq({tag, ".full0"}, 32'(full_vc0), 32'(mq0.size() == DEPTH));
    check_eq({tag, ".full1"}, 32'(full_vc1), 32'(mq1.size() == DEPTH));
    check_eq({tag, ".ovf"}, 32'(overflow_err), 32'(movf));
  endtask

  // One clock of the reference behaviour, from the current inputs and state.
  task automatic model_step();
    bit e0, e1, take0, take1, f0, f1;
    f0 = (mq0.size() == DEPTH);
    f1 = (mq1.size() == DEPTH);
    e0 = (mq0.size() > 0) && !mp0 && !pause_vc0;
    e1 = (mq1.size() > 0) && !mp1 && !pause_vc1;
    take0 = e0 && (!e1 || mrr_vc1);
    take1 = e1 && !take0;
    mvalid = take0 || take1;
    if (take0) begin mdata = mq0.pop_front(); mrr_vc1 = 0; end
    if (take1) begin mdata = mq1.pop_front(); mrr_vc1 = 1; end
    if (in_push) begin
      if (in_data[VC_BIT] == 1'b0) begin
        if (f0) movf = 1; else mq0.push_back(in_data);
      end else begin
        if (f1) movf = 1; else mq1.push_back(in_data);
      end
    end
    if (pause_vc0) mp0 = 1; else if (continue_vc0) mp0 = 0;
    if (pause_vc1) mp1 = 1; else if (continue_vc1) mp1 = 0;
  endtask

  // Drive inputs at the falling edge, advance one clock, compare at the next falling edge.
  task automatic step(input string tag, input logic [BS:0] d, input bit push,
                      input bit p0, input bit c0, input bit p1, input bit c1);
    in_data = d; in_push = push;
    pause_vc0 = p0; continue_vc0 = c0; pause_vc1 = p1; continue_vc1 = c1;
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, '0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [BS:0] w;
    reset = 1'b1; in_data = '0; in_push = 0;
    pause_vc0 = 0; continue_vc0 = 0; pause_vc1 = 0; continue_vc1 = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare_all("rst");
    reset = 1'b0;

    // Single VC0 word: one cycle to enqueue, next cycle emitted.
    step("t1push", 6'b001101, 1, 0, 0, 0, 0);
    idle("t1out", 2);

    // Back-to-back VC0 then VC1, then alternating with both loaded.
    step("t2a", 6'b011011, 1, 0, 0, 0, 0);
    step("t2b", 6'b111001, 1, 0, 0, 0, 0);
    idle("t2drain", 2);
    for (int i = 0; i < 3; i++) begin
      w = 6'(i); w[VC_BIT] = 1'b0;
      step("t2ld0", w, 1, 1, 0, 1, 0);
      w[VC_BIT] = 1'b1;
      step("t2ld1", w, 1, 1, 0, 1, 0);
    end
    step("t2go", '0, 0, 0, 1, 0, 1);
    idle("t2alt", 7);

    // VC0 held by pause while VC1 drains, then continue resumes VC0.
    for (int i = 0; i < 3; i++) begin
      w = 6'(8 + i); w[VC_BIT] = 1'b0;
      step("t3ld0", w, 1, 1, 0, 1, 0);
    end
    for (int i = 0; i < 2; i++) begin
      w = 6'(16 + i); w[VC_BIT] = 1'b1;
      step("t3ld1", w, 1, 1, 0, 1, 0);
    end
    step("t3p0", '0, 0, 1, 0, 0, 1);
    idle("t3vc1", 4);
    step("t3c0", '0, 0, 0, 1, 0, 0);
    idle("t3vc0", 4);

    // Overflow of VC1 while paused.
    for (int i = 0; i < 9; i++) begin
      w = 6'(i + 3); w[VC_BIT] = 1'b1;
      step("t4push", w, 1, 0, 0, 1, 0);
    end
    idle("t4hold", 2);

    // Pause and continue together: pause wins.
    step("t5both", '0, 0, 0, 0, 1, 1);
    idle("t5still", 3);

    // Asynchronous reset with words queued.
    #2 reset = 1'b1;
    #1 model_reset();
    compare_all("t6async");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    compare_all("t6rel");
    idle("t6quiet", 3);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      step("rnd", 6'($urandom), ($urandom_range(0, 99) < 65),
           ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 25),
           ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 25));
    end
    step("rndend", '0, 0, 0, 1, 0, 1);
    idle("rnddrain", 2 * DEPTH + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
